ysyx_22040759_wbu: RTL

Write-back unit for the ysyx_22040759 core: the single write port driver of the general-purpose register file. It accepts completed results from the execute unit (ALU/CSR/jump link values) and load responses from the load-store unit, and arbitrates between them. Load data is aligned and sign/zero-extended. The unit issues at most one registered register-file write per cycle, with a retire pulse.

---
 rtl/ysyx_22040759_wbu_pkg.sv | 18 +
 rtl/ysyx_22040759_load_ext.sv | 41 ++++
 rtl/ysyx_22040759_wbu.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ysyx_22040759_wbu_pkg.sv
// ysyx_22040759_wbu_pkg
// Shared definitions for the write-back unit: load funct3 encodings,
// default datapath width and register-index width.
package ysyx_22040759_wbu_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_W        = 5;

    // Load type encodings carried on lsu_funct3
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } loadFunct3_e;

endpackage

// File: rtl/ysyx_22040759_load_ext.sv
// ysyx_22040759_load_ext
// Combinational load alignment and sign/zero extension.
// Ports:
//   funct3_i   load type (LB/LH/LW/LBU/LHU)
//   off_i      byte address bits [1:0]
//   rdata_i    raw aligned memory word
//   data_o     aligned, extended value (0 for illegal funct3)
//   illegal_o  funct3 is not a supported load type
module ysyx_22040759_load_ext
    import ysyx_22040759_wbu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o,
    output logic            illegal_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Halfword selection only looks at off[1]; misaligned low bit is ignored.
    assign byteSel = rdata_i[8*off_i +: 8];
    assign halfSel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        data_o    = '0;
        illegal_o = 1'b0;
        case (funct3_i)
            LB:      data_o = {{(XLEN-8){byteSel[7]}}, byteSel};
            LBU:     data_o = {{(XLEN-8){1'b0}}, byteSel};
            LH:      data_o = {{(XLEN-16){halfSel[15]}}, halfSel};
            LHU:     data_o = {{(XLEN-16){1'b0}}, halfSel};
            LW:      data_o = rdata_i;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_22040759_wbu.sv
// ysyx_22040759_wbu
// Write-back unit: arbitrates EXU results and LSU load responses onto the
// single register-file write port through a registered output stage.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   exu_valid_i/exu_ready_o  EXU handshake; exu_rd_i, exu_wen_i, exu_data_i payload
//   lsu_valid_i/lsu_ready_o  LSU handshake; lsu_rd_i, lsu_funct3_i, lsu_off_i,
//                            lsu_rdata_i payload
//   gpr_wen_o, gpr_waddr_o, gpr_wdata_o   registered GPR write
//   retire_o                 one-cycle pulse per accepted instruction
//   lsu_err_o                one-cycle pulse when an illegal load funct3 retires
//   instret_o                64-bit retire counter (YSYX_22040759_WBU_INSTRET_EN only)
// Parameters: XLEN (32 only), LSU_PRIO (1 = LSU wins a conflict, 0 = EXU wins).
module ysyx_22040759_wbu
    import ysyx_22040759_wbu_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter bit LSU_PRIO = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exu_valid_i,
    output logic             exu_ready_o,
    input  logic [REG_W-1:0] exu_rd_i,
    input  logic             exu_wen_i,
    input  logic [XLEN-1:0]  exu_data_i,
    input  logic             lsu_valid_i,
    output logic             lsu_ready_o,
    input  logic [REG_W-1:0] lsu_rd_i,
    input  logic [2:0]       lsu_funct3_i,
    input  logic [1:0]       lsu_off_i,
    input  logic [XLEN-1:0]  lsu_rdata_i,
    output logic             gpr_wen_o,
    output logic [REG_W-1:0] gpr_waddr_o,
    output logic [XLEN-1:0]  gpr_wdata_o,
    output logic             retire_o,
    output logic             lsu_err_o
`ifdef YSYX_22040759_WBU_INSTRET_EN
    ,
    output logic [63:0]      instret_o
`endif
);

    logic            exuAccept;
    logic            lsuAccept;
    logic [XLEN-1:0] extData;
    logic            extIllegal;

    logic             gprWen_q,    gprWen_d;
    logic [REG_W-1:0] gprWaddr_q,  gprWaddr_d;
    logic [XLEN-1:0]  gprWdata_q,  gprWdata_d;
    logic             retire_q,    retire_d;
    logic             lsuErr_q,    lsuErr_d;

    ysyx_22040759_load_ext #(
        .XLEN(XLEN)
    ) u_load_ext (
        .funct3_i (lsu_funct3_i),
        .off_i    (lsu_off_i),
        .rdata_i  (lsu_rdata_i),
        .data_o   (extData),
        .illegal_o(extIllegal)
    );

    // Fixed-priority arbitration. The GPR port never stalls, so ready depends
    // only on the valids and reset, never on the output stage.
    always_comb begin
        if (LSU_PRIO) begin
            lsu_ready_o = !rst;
            exu_ready_o = !rst && !lsu_valid_i;
        end else begin
            exu_ready_o = !rst;
            lsu_ready_o = !rst && !exu_valid_i;
        end
    end

    assign exuAccept = exu_valid_i && exu_ready_o;
    assign lsuAccept = lsu_valid_i && lsu_ready_o;

    // Address/data hold their last value between accepts; wen, retire and
    // err are single-cycle pulses.
    always_comb begin
        gprWen_d   = 1'b0;
        gprWaddr_d = gprWaddr_q;
        gprWdata_d = gprWdata_q;
        retire_d   = 1'b0;
        lsuErr_d   = 1'b0;
        if (lsuAccept) begin
            gprWen_d   = (lsu_rd_i != '0);
            gprWaddr_d = lsu_rd_i;
            gprWdata_d = extData;
            retire_d   = 1'b1;
            lsuErr_d   = extIllegal;
        end else if (exuAccept) begin
            gprWen_d   = exu_wen_i && (exu_rd_i != '0);
            gprWaddr_d = exu_rd_i;
            gprWdata_d = exu_data_i;
            retire_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gprWen_q   <= 1'b0;
            gprWaddr_q <= '0;
            gprWdata_q <= '0;
            retire_q   <= 1'b0;
            lsuErr_q   <= 1'b0;
        end else begin
            gprWen_q   <= gprWen_d;
            gprWaddr_q <= gprWaddr_d;
            gprWdata_q <= gprWdata_d;
            retire_q   <= retire_d;
            lsuErr_q   <= lsuErr_d;
        end
    end

    assign gpr_wen_o   = gprWen_q;
    assign gpr_waddr_o = gprWaddr_q;
    assign gpr_wdata_o = gprWdata_q;
    assign retire_o    = retire_q;
    assign lsu_err_o   = lsuErr_q;

`ifdef YSYX_22040759_WBU_INSTRET_EN
    logic [63:0] instret_q;

    // Counts on the same edge that raises retire, so it already includes
    // the instruction whose pulse is visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (retire_d) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret_o = instret_q;
`endif

endmodule
